instruction_fetch_stage: RTL and testbench

- PC register plus IF/ID pipeline register for the MIPS pipeline; drives the word address into the instruction memory and captures the returned instruction.
- Handles sequential fetch, branch/jump redirect, load-use stall and control-hazard flush from downstream stages.
- Sits directly upstream of the instruction memory (address) and downstream of it (instruction capture).

---
 rtl/instruction_fetch_stage_if.sv | 29 ++
 rtl/instruction_fetch_stage.sv | 92 +++++++++
 tb/tb_instruction_fetch_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, redirect targets, instruction-memory port,
// IF/ID register outputs and fetch statistics.
interface instruction_fetch_stage_if;
    logic        stall;
    logic        flush;
    logic        branch;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instruction;
    logic [31:0] address;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pcplus4;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    // The fetch stage itself.
    modport master (
        input  stall, flush, branch, branch_target, jump, jump_target, instruction,
        output address, ifid_instruction, ifid_pcplus4, ifid_valid, fetch_count, stall_count
    );

    // Hazard unit, branch/jump resolution and instruction memory.
    modport slave (
        output stall, flush, branch, branch_target, jump, jump_target, instruction,
        input  address, ifid_instruction, ifid_pcplus4, ifid_valid, fetch_count, stall_count
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, redirect/stall handling and the IF/ID register.
// Define FETCH_STATS_EN to build the fetch and stall counters.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_stage_if.master  bus
);

    typedef enum logic {FILL, RUN} fetch_state_t;

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic [31:0]  ifid_instr_reg;
    logic [31:0]  ifid_pcplus4_reg;
    logic         ifid_valid_reg;
    logic         ifid_load;

    assign pc_plus4  = pc_reg + 32'd4;
    assign ifid_load = !bus.flush && !bus.stall;

    // Redirects outrank stall so a resolved control transfer is never dropped.
    always_comb begin
        pc_next = pc_plus4;
        if (bus.branch)
            pc_next = {bus.branch_target[31:2], 2'b00};
        else if (bus.jump)
            pc_next = {bus.jump_target[31:2], 2'b00};
        else if (bus.stall)
            pc_next = pc_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= FILL;
            pc_reg           <= RESET_PC;
            ifid_instr_reg   <= NOP_WORD;
            ifid_pcplus4_reg <= 32'h0;
            ifid_valid_reg   <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            if (bus.flush) begin
                ifid_instr_reg   <= NOP_WORD;
                ifid_pcplus4_reg <= 32'h0;
                ifid_valid_reg   <= 1'b0;
            end else if (!bus.stall) begin
                ifid_instr_reg   <= bus.instruction;
                ifid_pcplus4_reg <= pc_plus4;
                ifid_valid_reg   <= 1'b1;
            end
            case (state_reg)
                FILL:    if (ifid_load) state_reg <= RUN;
                RUN:     state_reg <= RUN;
                default: state_reg <= FILL;
            endcase
        end
    end

    assign bus.address          = pc_reg;
    assign bus.ifid_instruction = ifid_instr_reg;
    assign bus.ifid_pcplus4     = ifid_pcplus4_reg;
    assign bus.ifid_valid       = ifid_valid_reg;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] stall_count_reg;

    // Stall cycles are only counted once the pipeline has left the reset fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_reg <= 32'h0;
            stall_count_reg <= 32'h0;
        end else begin
            if (ifid_load)
                fetch_count_reg <= fetch_count_reg + 32'd1;
            if (state_reg == RUN && bus.stall && !bus.flush)
                stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_count_reg;
    assign bus.stall_count = stall_count_reg;
`else
    assign bus.fetch_count = 32'h0;
    assign bus.stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; instruction memory returns word i = i*4.
module tb_instruction_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic clk;
    logic rst;
    logic imem_x;
    int   vectors;
    int   miscompares;

    instruction_fetch_stage_if bus();

    instruction_fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.instruction = imem_x ? 32'hxxxx_xxxx : bus.address;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid);
        check({tag, ".address"}, bus.address, addr);
        check({tag, ".instr"},   bus.ifid_instruction, instr);
        check({tag, ".pcplus4"}, bus.ifid_pcplus4, pc4);
        check({tag, ".valid"},   {31'h0, bus.ifid_valid}, {31'h0, valid});
    endtask

    task automatic check_counts(input string tag, input logic [31:0] fetches,
                                input logic [31:0] stalls);
`ifdef FETCH_STATS_EN
        check({tag, ".fetch_count"}, bus.fetch_count, fetches);
        check({tag, ".stall_count"}, bus.stall_count, stalls);
`else
        check({tag, ".fetch_count"}, bus.fetch_count, 32'h0 & fetches);
        check({tag, ".stall_count"}, bus.stall_count, 32'h0 & stalls);
`endif
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        imem_x        = 1'b0;
        rst           = 1'b1;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch        = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;

        #1;
        check_ifid("reset", RESET_PC, NOP_WORD, 32'h0, 1'b0);
        check_counts("reset", 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_ifid("pre_first_edge", 32'h0, NOP_WORD, 32'h0, 1'b0);

        // Sequential fetch: after edge n, IF/ID = (n-1)*4 / n*4.
        for (int n = 1; n <= 4; n++) begin
            step();
            check_ifid($sformatf("seq%0d", n), n * 4, (n - 1) * 4, n * 4, 1'b1);
        end

        // Three stall cycles at PC=0x10.
        bus.stall = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            step();
            check_ifid($sformatf("stall%0d", s), 32'h10, 32'h0C, 32'h10, 1'b1);
        end
        check_counts("stall_end", 32'd4, 32'd3);
        bus.stall = 1'b0;
        step();
        check_ifid("stall_release", 32'h14, 32'h10, 32'h14, 1'b1);

        repeat (3) step();
        check_ifid("at_0x20", 32'h20, 32'h1C, 32'h20, 1'b1);

        // Branch with flush: bubble first, then the target instruction.
        bus.branch = 1'b1;
        bus.branch_target = 32'h40;
        bus.flush = 1'b1;
        step();
        check_ifid("branch_flush", 32'h40, NOP_WORD, 32'h0, 1'b0);
        check_counts("branch_flush", 32'd8, 32'd3);
        bus.branch = 1'b0;
        bus.flush = 1'b0;
        step();
        check_ifid("branch_target", 32'h44, 32'h40, 32'h44, 1'b1);

        // Jump to a misaligned target; low bits are dropped.
        bus.jump = 1'b1;
        bus.jump_target = 32'h31;
        step();
        check_ifid("jump_align", 32'h30, 32'h44, 32'h48, 1'b1);

        // Stall + Jump + Branch: branch wins for PC, IF/ID holds.
        bus.stall = 1'b1;
        bus.jump_target = 32'h83;
        bus.branch = 1'b1;
        bus.branch_target = 32'h100;
        step();
        check_ifid("branch_wins", 32'h100, 32'h44, 32'h48, 1'b1);
        check_counts("branch_wins", 32'd10, 32'd4);
        bus.stall = 1'b0;
        bus.branch = 1'b0;

        // PC+4 wrap from the top of the address space.
        bus.jump_target = 32'hFFFF_FFFE;
        step();
        check_ifid("to_top", 32'hFFFF_FFFC, 32'h100, 32'h104, 1'b1);
        bus.jump = 1'b0;
        step();
        check_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // Unknown memory data is captured unchanged.
        imem_x = 1'b1;
        step();
        check("x_capture", bus.ifid_instruction, 32'hxxxx_xxxx);
        imem_x = 1'b0;

        // Asynchronous reset in the middle of a stall at PC=0x50.
        bus.jump = 1'b1;
        bus.jump_target = 32'h50;
        step();
        bus.jump = 1'b0;
        bus.stall = 1'b1;
        step();
        check("stall_0x50", bus.address, 32'h50);
        #2;
        rst = 1'b1;
        #1;
        check_ifid("async_reset", RESET_PC, NOP_WORD, 32'h0, 1'b0);
        check_counts("async_reset", 32'd0, 32'd0);
        rst = 1'b0;
        bus.stall = 1'b0;
        step();
        check_ifid("post_reset", 32'h4, 32'h0, 32'h4, 1'b1);

        // Stall and flush together: PC holds, IF/ID bubbles, no stall counted.
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        check_ifid("stall_flush", 32'h4, NOP_WORD, 32'h0, 1'b0);
        check_counts("stall_flush", 32'd1, 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
